// File: rtl/glitch_pkg.sv
// Shared definitions for the multi-pulse glitch sequencer: FSM states,
// trigger-mode encodings and a constant-evaluable clog2.
package glitch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    GAP       = 2'd2,
    PULSE     = 2'd3
  } state_t;

  localparam logic TRIG_ARM  = 1'b0;
  localparam logic TRIG_EDGE = 1'b1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/glitch_timer.sv
// Loadable down-counter shared by gap and pulse phases; parks at zero and
// never wraps, so a loaded value of N-1 yields exactly N cycles.
module glitch_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-pulse glitch timing engine: plays a table of (offset, duration) pairs
// on the active-low glitch control after an arm or an external trigger edge.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int NUM_PULSES = 4,
  localparam int IDX_W     = (clog2(NUM_PULSES) > 1) ? clog2(NUM_PULSES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_ofs,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic [IDX_W:0]   cfg_npulse,
  input  logic             trig_mode,
  input  logic             arm,
  input  logic             trig,
  input  logic             abort,
  output logic             glitch_n,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pulse_idx
);

  localparam int NP_W = IDX_W + 1;

  state_t             state;
  state_t             state_nxt;
  logic [2*CNT_W-1:0] tbl [NUM_PULSES];
  logic [CNT_W-1:0]   ofs_v [NUM_PULSES];
  logic [CNT_W-1:0]   dur_v [NUM_PULSES];
  logic               wr_ok;
  logic               trig_d;
  logic               trig_ev;
  logic [NP_W-1:0]    npulse_q;
  int                 np_sel;
  logic               t_load;
  logic               t_en;
  logic               t_zero;
  logic [CNT_W-1:0]   t_val;
  logic [IDX_W-1:0]   idx_nxt;
  logic               done_nxt;
  logic               start;
  logic               found;
  int                 seek_from;

  // Entry count of 0 or beyond the table depth means "play the whole table".
  function automatic logic [NP_W-1:0] sat_npulse(input logic [NP_W-1:0] n);
    if ((n == '0) || (int'(n) > NUM_PULSES)) begin
      return NP_W'(NUM_PULSES);
    end
    return n;
  endfunction

  assign wr_ok   = cfg_we && (state == IDLE) && (int'(cfg_idx) < NUM_PULSES);
  assign trig_ev = trig && !trig_d;
  assign np_sel  = (state == IDLE) ? int'(sat_npulse(cfg_npulse)) : int'(npulse_q);
  assign t_en    = (state == GAP) || (state == PULSE);

  // Table storage: deliberately outside reset so a configured table survives rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tbl[cfg_idx] <= {cfg_ofs, cfg_dur};
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && arm && !abort) begin
      npulse_q <= sat_npulse(cfg_npulse);
    end
  end

  // Forward a write issued alongside arm so the first entry uses the new values.
  always_comb begin
    for (int k = 0; k < NUM_PULSES; k++) begin
      ofs_v[k] = tbl[k][2*CNT_W-1:CNT_W];
      dur_v[k] = tbl[k][CNT_W-1:0];
      if (wr_ok && (cfg_idx == IDX_W'(k))) begin
        ofs_v[k] = cfg_ofs;
        dur_v[k] = cfg_dur;
      end
    end
  end

  glitch_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = pulse_idx;
    done_nxt  = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    start     = 1'b0;
    found     = 1'b0;
    seek_from = 0;

    case (state)
      IDLE: begin
        if (arm) begin
          case (trig_mode)
            TRIG_ARM:  start     = 1'b1;
            TRIG_EDGE: state_nxt = WAIT_TRIG;
          endcase
        end
      end
      WAIT_TRIG: begin
        if (trig_ev) begin
          start = 1'b1;
        end
      end
      GAP: begin
        if (t_zero) begin
          if (dur_v[pulse_idx] != '0) begin
            state_nxt = PULSE;
            t_load    = 1'b1;
            t_val     = dur_v[pulse_idx] - CNT_W'(1);
          end else begin
            start     = 1'b1;
            seek_from = int'(pulse_idx) + 1;
          end
        end
      end
      PULSE: begin
        if (t_zero) begin
          start     = 1'b1;
          seek_from = int'(pulse_idx) + 1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Find the next entry with any cycles to spend; entries with zero gap and
    // zero duration take no time at all, so they are skipped in the same cycle.
    if (start) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      done_nxt  = 1'b1;
      for (int k = 0; k < NUM_PULSES; k++) begin
        if (!found && (k >= seek_from) && (k < np_sel)) begin
          if (ofs_v[k] != '0) begin
            found     = 1'b1;
            state_nxt = GAP;
            idx_nxt   = IDX_W'(k);
            t_load    = 1'b1;
            t_val     = ofs_v[k] - CNT_W'(1);
          end else if (dur_v[k] != '0) begin
            found     = 1'b1;
            state_nxt = PULSE;
            idx_nxt   = IDX_W'(k);
            t_load    = 1'b1;
            t_val     = dur_v[k] - CNT_W'(1);
          end
        end
      end
      if (found) begin
        done_nxt = 1'b0;
      end
    end

    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      done_nxt  = 1'b0;
      t_load    = 1'b0;
    end
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      glitch_n  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      trig_d    <= 1'b0;
    end else begin
      state     <= state_nxt;
      glitch_n  <= (state_nxt != PULSE);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      pulse_idx <= idx_nxt;
      trig_d    <= trig;
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: directed playbacks push expected
// busy/pulse_idx/low-window/done events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_glitch_sequencer;

  localparam int CNT_W      = 8;
  localparam int NUM_PULSES = 4;
  localparam int IDX_W      = 2;

  localparam int K_BUSY = 0;
  localparam int K_IDX  = 1;
  localparam int K_LOW  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int t;
    int len;
    int val;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [CNT_W-1:0] cfg_ofs = '0;
  logic [CNT_W-1:0] cfg_dur = '0;
  logic [IDX_W:0]   cfg_npulse = '0;
  logic             trig_mode = 1'b0;
  logic             arm = 1'b0;
  logic             trig = 1'b0;
  logic             abort = 1'b0;
  logic             glitch_n;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] pulse_idx;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  bit  mon_en = 1'b0;
  int  prev_busy = 0;
  int  prev_idx = 0;
  bit  in_low = 1'b0;
  int  low_t = 0;
  int  low_idx = 0;

  glitch_sequencer #(
    .CNT_W      (CNT_W),
    .NUM_PULSES (NUM_PULSES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_ofs    (cfg_ofs),
    .cfg_dur    (cfg_dur),
    .cfg_npulse (cfg_npulse),
    .trig_mode  (trig_mode),
    .arm        (arm),
    .trig       (trig),
    .abort      (abort),
    .glitch_n   (glitch_n),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_BUSY:  return "busy";
      K_IDX:   return "pulse_idx";
      K_LOW:   return "low_window";
      default: return "done";
    endcase
  endfunction

  task automatic push(input int kind, input int t, input int len, input int val);
    exp_q.push_back('{kind, t, len, val});
  endtask

  task automatic match(input int kind, input int t, input int len, input int val);
    int  pos;
    ev_t e;
    pos = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((pos < 0) && (exp_q[i].kind == kind)) pos = i;
    end
    checks++;
    if (pos < 0) begin
      errors++;
      $display("FAIL %s: unexpected event got t=%0d len=%0d val=%0d, required none",
               kname(kind), t, len, val);
    end else begin
      e = exp_q[pos];
      exp_q.delete(pos);
      if ((e.t != t) || (e.len != len) || (e.val != val)) begin
        errors++;
        $display("FAIL %s: got t=%0d len=%0d val=%0d, required t=%0d len=%0d val=%0d",
                 kname(kind), t, len, val, e.t, e.len, e.val);
      end
    end
  endtask

  // t is the clock edge at which the observed value is sampled by downstream logic.
  always @(negedge clk) begin
    int t;
    if (mon_en) begin
      t = cyc + 1;
      if (int'(busy) != prev_busy) begin
        match(K_BUSY, t, 0, int'(busy));
        prev_busy = int'(busy);
      end
      if (int'(pulse_idx) != prev_idx) begin
        match(K_IDX, t, 0, int'(pulse_idx));
        prev_idx = int'(pulse_idx);
      end
      if (!glitch_n && !in_low) begin
        in_low  = 1'b1;
        low_t   = t;
        low_idx = int'(pulse_idx);
      end else if (glitch_n && in_low) begin
        in_low = 1'b0;
        match(K_LOW, low_t, t - low_t, low_idx);
      end
      if (done) match(K_DONE, t, 0, 0);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events still pending after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic cfg_write(input int idx, input int ofs, input int dur);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_ofs = CNT_W'(ofs);
    cfg_dur = CNT_W'(dur);
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic do_arm(input logic mode, input int np);
    trig_mode  = mode;
    cfg_npulse = (IDX_W+1)'(np);
    arm        = 1'b1;
    @(negedge clk);
    arm        = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int e;
    @(negedge clk);
    wait_cyc(3);
    chk("reset glitch_n", int'(glitch_n), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset pulse_idx", int'(pulse_idx), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // single pulse, arm sampled at edge 10
    cfg_write(0, 5, 3);
    wait_cyc(9);
    e = cyc + 1;
    push(K_BUSY, 11, 0, 1);
    push(K_LOW, 16, 3, 0);
    push(K_DONE, 19, 0, 0);
    push(K_BUSY, 19, 0, 0);
    do_arm(1'b0, 1);
    drain(40);

    // edge-triggered: trig already high at arm must not fire
    trig = 1'b1;
    cfg_write(0, 3, 2);
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    do_arm(1'b1, 1);
    wait_cyc(44);
    trig = 1'b0;
    wait_cyc(49);
    trig = 1'b1;
    push(K_LOW, 54, 2, 0);
    push(K_DONE, 56, 0, 0);
    push(K_BUSY, 56, 0, 0);
    drain(30);
    trig = 1'b0;

    // three entries, last two merged
    cfg_write(0, 2, 1);
    cfg_write(1, 4, 2);
    cfg_write(2, 0, 3);
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 3, 1, 0);
    push(K_IDX, e + 4, 0, 1);
    push(K_LOW, e + 8, 5, 1);
    push(K_IDX, e + 10, 0, 2);
    push(K_DONE, e + 13, 0, 0);
    push(K_BUSY, e + 13, 0, 0);
    push(K_IDX, e + 13, 0, 0);
    do_arm(1'b0, 3);
    drain(40);

    // abort in the middle of entry 1's pulse
    cfg_write(0, 1, 2);
    cfg_write(1, 2, 6);
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 2, 2, 0);
    push(K_IDX, e + 4, 0, 1);
    push(K_LOW, e + 6, 3, 1);
    push(K_BUSY, e + 9, 0, 0);
    push(K_IDX, e + 9, 0, 0);
    do_arm(1'b0, 2);
    wait_cyc(e + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain(40);

    // abort beats arm in the same cycle: nothing may happen
    abort = 1'b1;
    do_arm(1'b0, 2);
    abort = 1'b0;
    drain(10);

    // replay after abort starts from entry 0
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 2, 2, 0);
    push(K_IDX, e + 4, 0, 1);
    push(K_LOW, e + 6, 6, 1);
    push(K_DONE, e + 12, 0, 0);
    push(K_BUSY, e + 12, 0, 0);
    push(K_IDX, e + 12, 0, 0);
    do_arm(1'b0, 2);
    drain(40);

    // zero-duration final entry; writes while busy must be ignored
    cfg_write(0, 0, 4);
    cfg_write(1, 7, 0);
    for (int r = 0; r < 2; r++) begin
      e = cyc + 1;
      push(K_BUSY, e + 1, 0, 1);
      push(K_LOW, e + 1, 4, 0);
      push(K_IDX, e + 5, 0, 1);
      push(K_DONE, e + 12, 0, 0);
      push(K_BUSY, e + 12, 0, 0);
      push(K_IDX, e + 12, 0, 0);
      do_arm(1'b0, 2);
      cfg_write(0, 9, 9);
      cfg_write(1, 1, 5);
      drain(40);
    end

    // write in the arm cycle is used by that playback
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 2, 2, 0);
    push(K_DONE, e + 4, 0, 0);
    push(K_BUSY, e + 4, 0, 0);
    cfg_we  = 1'b1;
    cfg_idx = '0;
    cfg_ofs = CNT_W'(1);
    cfg_dur = CNT_W'(2);
    do_arm(1'b0, 1);
    cfg_we  = 1'b0;
    drain(20);

    // full-scale counts: no wrap
    cfg_write(0, 255, 255);
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 256, 255, 0);
    push(K_DONE, e + 511, 0, 0);
    push(K_BUSY, e + 511, 0, 0);
    do_arm(1'b0, 1);
    drain(600);

    // rst during entry 1's gap
    cfg_write(0, 0, 1);
    cfg_write(1, 200, 1);
    e = cyc + 1;
    push(K_BUSY, e + 1, 0, 1);
    push(K_LOW, e + 1, 1, 0);
    push(K_IDX, e + 2, 0, 1);
    push(K_BUSY, e + 51, 0, 0);
    push(K_IDX, e + 51, 0, 0);
    do_arm(1'b0, 2);
    wait_cyc(e + 49);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid-gap glitch_n", int'(glitch_n), 1);
    chk("rst mid-gap busy", int'(busy), 0);
    chk("rst mid-gap done", int'(done), 0);
    chk("rst mid-gap pulse_idx", int'(pulse_idx), 0);
    rst = 1'b0;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Multi-pulse glitch timing engine; the parametrised successor to the single offset/duration counter pair in the iCEstick glitcher. It holds a table of up to NUM_PULSES (offset, duration) pairs and, after a trigger, plays them back in order on the active-low glitch MOSFET control. It sits between the command processor (table writes, arm, abort) and the top-level tri-state driver on power_ctrl.

## Interface
- CNT_W, 32, width of every offset/duration count, in clk cycles
- NUM_PULSES, 4, table depth, ≥1; IDX_W = max(1, clog2(NUM_PULSES))

Ports:
- clk  in  1  system clock (100 MHz PLL output)
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe; ignored unless state is IDLE
- cfg_idx  in  IDX_W  table entry written
- cfg_ofs  in  CNT_W  gap before pulse: from trigger for entry 0, from end of previous pulse otherwise
- cfg_dur  in  CNT_W  pulse length; 0 = entry produces no pulse
- cfg_npulse  in  IDX_W+1  entries to play, latched on arm; 0 or >NUM_PULSES is clamped to NUM_PULSES
- trig_mode  in  1  0 = start on arm, 1 = start on rising edge of trig; latched on arm
- arm  in  1  one-cycle start request
- trig  in  1  external trigger, already synchronous to clk
- abort  in  1  return to IDLE immediately
- glitch_n  out  1  0 = glitch active; registered
- busy  out  1  1 in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion
- pulse_idx  out  IDX_W  entry currently being played

## Operation
- States: IDLE, WAIT_TRIG, GAP, PULSE
- IDLE: arm with trig_mode=0 → GAP for entry 0; arm with trig_mode=1 → WAIT_TRIG; arm in any other state is ignored
- WAIT_TRIG: trigger event = trig high this cycle and low in the previous cycle, using a registered trig_d. trig_d updates every cycle, including in IDLE. A trig already high at arm does not fire. The trigger event → GAP for entry 0.
- GAP: loads ofs[i] and counts down; on reaching 0 → PULSE, or skips straight to the next entry when dur[i]=0
- PULSE: glitch_n=0 for exactly dur[i] cycles, then moves to the next entry's GAP. After the last entry → IDLE with done.
- Arithmetic: counters are unsigned CNT_W, count down, and never wrap. Maximum values (2^CNT_W−1) are legal.
- Table contents survive rst; only the control state resets. Table entries are undefined until written.
- abort takes priority over every other input, including arm in the same cycle. It forces IDLE and glitch_n=1 on the next edge, with no done pulse.
- rst mid-operation behaves like abort. rst has priority over abort.
- cfg_we in the same cycle as arm: the write is applied, and the latched playback uses the new entry.

## Timing
- Reset values: glitch_n=1, busy=0, done=0, pulse_idx=0, state IDLE, trig_d=0
- Define edge E as the edge where arm is sampled (mode 0) or where the trigger event is sampled (mode 1). busy is 1 from E+1.
- Pulse 0: glitch_n low from edge E+1+ofs[0] for dur[0] cycles. With ofs=0, glitch_n is low at E+1.
- Pulse i>0: first low cycle is ofs[i] cycles after pulse i−1's last low cycle. With ofs[i]=0, pulse i is back-to-back with pulse i−1 (merged low window).
- Zero-duration entries consume their gap cycles only; they add no extra cycle.
- done is high on the cycle after the final pulse's last low cycle, or after the final gap if that entry has dur=0. busy falls in the same cycle.
- pulse_idx updates on the cycle the GAP for that entry begins.

## Structure
- Shared package glitch_pkg: state enum, trig_mode constants (TRIG_ARM, TRIG_EDGE), a clog2 function
- One sub-module, glitch_timer: a loadable CNT_W down-counter with load, enable and zero outputs. It is instantiated once and reused for both gaps and pulses.
- Table is a register array of NUM_PULSES × 2·CNT_W.

## Test plan
- npulse=1, mode 0, ofs=5, dur=3, arm at edge 10 → glitch_n low on edges 16–18, done at edge 19
- npulse=3, ofs={2,4,0}, dur={1,2,3}, mode 0 → low windows of 1, 2 and 3 cycles, gaps of 2 and 4 cycles, pulses 1 and 2 merged into a 5-cycle low; done once
- Mode 1: arm while trig=1, hold trig high → no start. Drop trig, raise it at edge 50 → glitch_n low at 51+ofs[0].
- abort during PULSE of entry 1 → glitch_n=1 next edge, busy=0, no done. A following arm replays from entry 0.
- dur[1]=0, npulse=2, ofs={0,7} → a single pulse, and done 7 cycles after pulse 0 ends. cfg_we while busy leaves the table unchanged (verified by a replay).
- CNT_W=8, ofs=255, dur=255 → no wrap: exact 255-cycle gap and 255-cycle pulse. rst mid-gap → all outputs at their reset values on the next edge.
